ad7606_sample_sched: RTL and testbench

//  Sequencer for the AD7606 capture block. Issues conversion starts at a fixed

---
 rtl/ad7606_sample_sched.sv | 161 ++++++++++++++++
 tb/tb_ad7606_sample_sched.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ad7606_sample_sched.sv
// Sample-rate sequencer for the AD7606 capture FIFO: issues conversion starts,
// drains one CHANNELS-word frame per start and streams it with channel tags.
module ad7606_sample_sched #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CH_W     = 3,
  parameter int unsigned PERIOD   = 2500,
  parameter int unsigned TIMEOUT  = 5000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            enable_i,
  output logic            start_o,
  input  logic [5:0]      rdusedw_i,
  output logic            rdreq_o,
  input  logic [15:0]     ad_data_i,
  output logic [15:0]     sample_data_o,
  output logic [CH_W-1:0] sample_ch_o,
  output logic            sample_valid_o,
  output logic            sample_last_o,
  input  logic            sample_ready_i,
  output logic            frame_busy_o,
  output logic            timeout_err_o,
  input  logic            clear_err_i,
  output logic [15:0]     overrun_cnt_o
);

  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam int unsigned TMO_W = $clog2(TIMEOUT);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             start_q, start_d;
  logic             rdreq_q, rdreq_d;
  logic [15:0]      data_q, data_d;
  logic [CH_W-1:0]  sch_q, sch_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [15:0]      ovr_q, ovr_d;
  logic             tick;
  logic             err_set;

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      ch_q    <= '0;
      start_q <= 1'b0;
      rdreq_q <= 1'b0;
      data_q  <= '0;
      sch_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ch_q    <= ch_d;
      start_q <= start_d;
      rdreq_q <= rdreq_d;
      data_q  <= data_d;
      sch_q   <= sch_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  // Sample timer, tick arbitration and frame FSM
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    ch_d    = ch_q;
    start_d = 1'b0;
    rdreq_d = 1'b0;
    data_d  = data_q;
    sch_d   = sch_q;
    valid_d = valid_q;
    last_d  = last_q;
    ovr_d   = ovr_q;
    err_set = 1'b0;

    tick = enable_i && (cnt_q == CNT_W'(PERIOD - 1));
    if (!enable_i || tick) cnt_d = '0;
    else                   cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rdusedw_i >= 6'(CHANNELS)) begin
          rdreq_d = 1'b1;
          state_d = ST_READ;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_READ: state_d = ST_LATCH;
      ST_LATCH: begin
        data_d  = ad_data_i;
        sch_d   = ch_q;
        last_d  = (ch_q == CH_W'(CHANNELS - 1));
        valid_d = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (sample_ready_i) begin
          valid_d = 1'b0;
          if (last_q) begin
            ch_d    = '0;
            state_d = ST_IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            rdreq_d = 1'b1;
            state_d = ST_READ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick that cannot start a frame is an overrun
    if (tick && (state_q != ST_IDLE) && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;

    if (err_set)          err_d = 1'b1;
    else if (clear_err_i) err_d = 1'b0;
    else                  err_d = err_q;
  end

  assign start_o        = start_q;
  assign rdreq_o        = rdreq_q;
  assign sample_data_o  = data_q;
  assign sample_ch_o    = sch_q;
  assign sample_valid_o = valid_q;
  assign sample_last_o  = last_q;
  assign timeout_err_o  = err_q;
  assign overrun_cnt_o  = ovr_q;
  assign frame_busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ad7606_sample_sched.sv
// Scoreboard bench for ad7606_sample_sched with a capture FIFO model.
module tb_ad7606_sample_sched;

  logic        clk = 1'b0;
  logic        rst, enable, start, rdreq, sample_valid, sample_last, sample_ready;
  logic        frame_busy, timeout_err, clear_err;
  logic [5:0]  rdusedw = 6'd0;
  logic [15:0] ad_data = 16'd0;
  logic [15:0] sample_data, overrun_cnt;
  logic [2:0]  sample_ch;

  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, en_cyc = 0, fill_cd = 0;
  int          rdreq_cnt = 0, xfer_cnt = 0, last_cnt = 0, n0;
  int          start_cyc[$];
  logic [15:0] fifo_q[$];
  logic [19:0] exp_q[$];
  logic [19:0] e;
  logic        fill_en = 1'b0, en_prev = 1'b0, err_prev = 1'b0, stall_prev = 1'b0;
  logic [15:0] hold_data = 16'd0, base = 16'h1000, w;
  logic [2:0]  hold_ch = 3'd0;

  always #5 clk = ~clk;

  ad7606_sample_sched #(.CHANNELS(8), .CH_W(3), .PERIOD(100), .TIMEOUT(50)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .start_o(start),
    .rdusedw_i(rdusedw), .rdreq_o(rdreq), .ad_data_i(ad_data),
    .sample_data_o(sample_data), .sample_ch_o(sample_ch),
    .sample_valid_o(sample_valid), .sample_last_o(sample_last),
    .sample_ready_i(sample_ready), .frame_busy_o(frame_busy),
    .timeout_err_o(timeout_err), .clear_err_i(clear_err),
    .overrun_cnt_o(overrun_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_start"}, 32'(start), 0);
    check({tag, "_rdreq"}, 32'(rdreq), 0);
    check({tag, "_valid"}, 32'(sample_valid), 0);
    check({tag, "_data"},  32'(sample_data), 0);
    check({tag, "_ch"},    32'(sample_ch), 0);
    check({tag, "_last"},  32'(sample_last), 0);
    check({tag, "_busy"},  32'(frame_busy), 0);
    check({tag, "_err"},   32'(timeout_err), 0);
    check({tag, "_ovr"},   32'(overrun_cnt), 0);
  endtask

  // FIFO model, stall monitor and scoreboard, all sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (enable && !en_prev) en_cyc = cyc;
      en_prev = enable;
      if (stall_prev) begin
        check("stall_valid", 32'(sample_valid), 1);
        check("stall_data",  32'(sample_data), 32'(hold_data));
        check("stall_ch",    32'(sample_ch), 32'(hold_ch));
        check("stall_rdreq", 32'(rdreq), 0);
      end
      stall_prev = sample_valid && !sample_ready && !rst;
      hold_data  = sample_data;
      hold_ch    = sample_ch;
      if (sample_valid && sample_ready) begin
        xfer_cnt++;
        if (sample_last) last_cnt++;
        if (exp_q.size() == 0) check("sb_depth", 32'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          check("sb_data", 32'(sample_data), 32'(e[15:0]));
          check("sb_ch",   32'(sample_ch), 32'(e[18:16]));
          check("sb_last", 32'(sample_last), 32'(e[19]));
        end
      end
      if (rdreq) begin
        rdreq_cnt++;
        if (fifo_q.size() > 0) ad_data = fifo_q.pop_front();
      end
      if (fill_cd > 0) begin
        fill_cd--;
        if (fill_cd == 0 && fill_en) begin
          for (int k = 0; k < 8; k++) begin
            w = base + 16'(k);
            fifo_q.push_back(w);
            exp_q.push_back({(k == 7), 3'(k), w});
          end
          base = base + 16'h10;
        end
      end
      if (start) begin
        start_cyc.push_back(cyc);
        fill_cd = 20;
      end
      rdusedw = 6'(fifo_q.size());
      if (timeout_err && !err_prev) begin
        check("tmo_lat",  32'(cyc - start_cyc[$]), 50);
        check("tmo_busy", 32'(frame_busy), 0);
      end
      err_prev = timeout_err;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; sample_ready = 1'b1; clear_err = 1'b0;
    step(3);
    check_idle_outputs("rst");
    rst = 1'b0;
    step(2);

    // Empty FIFO: periodic starts, each frame times out
    enable = 1'b1;
    for (int i = 0; i < 400 && start_cyc.size() < 3; i++) step();
    check("t1_starts", 32'(start_cyc.size()), 3);
    if (start_cyc.size() >= 3) begin
      check("t1_first", 32'(start_cyc[0] - en_cyc), 100);
      check("t1_gap1",  32'(start_cyc[1] - start_cyc[0]), 100);
      check("t1_gap2",  32'(start_cyc[2] - start_cyc[1]), 100);
    end
    enable = 1'b0;
    step(60);
    check("t5_err",   32'(timeout_err), 1);
    check("t5_busy",  32'(frame_busy), 0);
    check("t5_rdreq", 32'(rdreq_cnt), 0);
    check("t1_ovr",   32'(overrun_cnt), 0);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    check("t5_clear", 32'(timeout_err), 0);

    // Full frame, ready always high
    fill_en = 1'b1; rdreq_cnt = 0; xfer_cnt = 0; last_cnt = 0;
    n0 = start_cyc.size();
    enable = 1'b1;
    for (int i = 0; i < 200 && start_cyc.size() < n0 + 1; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 200 && !(xfer_cnt == 8 && !frame_busy); i++) step();
    check("t2_xfer",  32'(xfer_cnt), 8);
    check("t2_rdreq", 32'(rdreq_cnt), 8);
    check("t2_last",  32'(last_cnt), 1);
    check("t2_sb",    32'(exp_q.size()), 0);

    // Stall on channel 3
    rdreq_cnt = 0; xfer_cnt = 0;
    n0 = start_cyc.size();
    enable = 1'b1;
    for (int i = 0; i < 200 && start_cyc.size() < n0 + 1; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 200 && !(sample_valid && sample_ch == 3'd3); i++) step();
    check("t3_reach", 32'(sample_ch), 3);
    sample_ready = 1'b0;
    step(10);
    sample_ready = 1'b1;
    for (int i = 0; i < 200 && !(xfer_cnt == 8 && !frame_busy); i++) step();
    check("t3_xfer",  32'(xfer_cnt), 8);
    check("t3_rdreq", 32'(rdreq_cnt), 8);

    // Long stall drops two ticks
    rdreq_cnt = 0; xfer_cnt = 0;
    n0 = start_cyc.size();
    enable = 1'b1;
    for (int i = 0; i < 200 && start_cyc.size() < n0 + 1; i++) step();
    for (int i = 0; i < 100 && !sample_valid; i++) step();
    sample_ready = 1'b0;
    step(250);
    sample_ready = 1'b1;
    for (int i = 0; i < 200 && start_cyc.size() < n0 + 2; i++) step();
    enable = 1'b0;
    check("t4_ovr", 32'(overrun_cnt), 2);
    check("t4_starts", 32'(start_cyc.size() - n0), 2);
    if (start_cyc.size() >= n0 + 2)
      check("t4_gap", 32'(start_cyc[n0+1] - start_cyc[n0]), 300);
    for (int i = 0; i < 200 && !(xfer_cnt == 16 && !frame_busy); i++) step();
    check("t4_xfer",  32'(xfer_cnt), 16);
    check("t4_rdreq", 32'(rdreq_cnt), 16);

    // Reset during OUT on channel 4, then a fresh frame
    n0 = start_cyc.size();
    enable = 1'b1;
    for (int i = 0; i < 200 && start_cyc.size() < n0 + 1; i++) step();
    for (int i = 0; i < 200 && !(sample_valid && sample_ch == 3'd4); i++) step();
    check("t6_reach", 32'(sample_ch), 4);
    rst = 1'b1;
    step();
    check_idle_outputs("t6");
    rst = 1'b0;
    exp_q.delete(); fifo_q.delete(); fill_cd = 0;
    xfer_cnt = 0; rdreq_cnt = 0; last_cnt = 0;
    n0 = start_cyc.size();
    for (int i = 0; i < 200 && start_cyc.size() < n0 + 1; i++) step();
    enable = 1'b0;
    for (int i = 0; i < 200 && !(xfer_cnt == 8 && !frame_busy); i++) step();
    check("t6_xfer",  32'(xfer_cnt), 8);
    check("t6_rdreq", 32'(rdreq_cnt), 8);
    check("t6_last",  32'(last_cnt), 1);
    check("t6_err",   32'(timeout_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
